// File: rtl/bitonic_pkg.sv
// Shared constants and width helpers for the bitonic sorter and its request scheduler.
package bitonic_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int LOG_INPUT_DEF  = 5;

  // Ceiling log2, never less than 1 so it can always size a vector.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int vec_w(input int data_width, input int log_input);
    return data_width * (1 << log_input);
  endfunction

  function automatic int id_w(input int num_req);
    return clog2(num_req);
  endfunction

endpackage

// File: rtl/sort_sched_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; head reads as 0 when empty.
module sort_sched_fifo
  import bitonic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok  = push && (count != CNT_W'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately not reset; the count gate above keeps stale words off the output.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/bitonic_sort_sched.sv
// Round-robin scheduler sharing one fixed-latency sorter among NUM_REQ requesters, with credit-based issue.
module bitonic_sort_sched
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG_INPUT  = LOG_INPUT_DEF,
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = LOG_INPUT,
  parameter int DEPTH      = 8,
  localparam int VEC_W = vec_w(DATA_WIDTH, LOG_INPUT),
  localparam int ID_W  = id_w(NUM_REQ),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VEC_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     srt_x_valid,
  output logic [VEC_W-1:0]         srt_x,
  input  logic                     srt_y_valid,
  input  logic [VEC_W-1:0]         srt_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [VEC_W-1:0]         rsp_data,
  output logic                     err
);

  if (DEPTH < LATENCY + 1) begin : g_depth_check
    $error("bitonic_sort_sched: DEPTH must be at least LATENCY+1");
  end

  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic [VEC_W-1:0]      win_data;
  logic                  credit;
  logic                  handshake;
  logic                  rsp_pop;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      occ;
  logic [ID_W-1:0]       tag_head;
  logic                  tag_pop;
  logic [ID_W+VEC_W-1:0] rsp_head;

  // NOTE: every signal gets a default before the loop, so no path through this block can infer a latch.
  always_comb begin
    winner   = last_grant;
    found    = 1'b0;
    cand     = last_grant;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = req_data[(NUM_REQ-1-i)*VEC_W +: VEC_W];
    end
  end

  // A response leaving this cycle frees its slot now, which is what sustains one issue per cycle.
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign credit    = (int'(inflight) + int'(occ) - int'(rsp_pop)) < DEPTH;
  assign handshake = found & credit & rst;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant  <= ID_W'(NUM_REQ - 1);
      srt_x_valid <= 1'b0;
      srt_x       <= '0;
      err         <= 1'b0;
    end else begin
      srt_x_valid <= handshake;
      if (handshake) begin
        last_grant <= winner;
        srt_x      <= win_data;
      end
      if (srt_y_valid && (inflight == '0)) err <= 1'b1;
    end
  end

  // Tag occupancy is exactly the number of vectors inside the sorter.
  assign tag_pop = srt_y_valid && (inflight != '0);

  sort_sched_fifo #(
    .WIDTH(ID_W),
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (handshake),
    .push_data(winner),
    .pop      (tag_pop),
    .pop_data (tag_head),
    .count    (inflight)
  );

  sort_sched_fifo #(
    .WIDTH(ID_W + VEC_W),
    .DEPTH(DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (tag_pop),
    .push_data({tag_head, srt_y}),
    .pop      (rsp_pop),
    .pop_data (rsp_head),
    .count    (occ)
  );

  assign rsp_valid = (occ != '0);
  assign rsp_id    = rsp_head[VEC_W +: ID_W];
  assign rsp_data  = rsp_head[VEC_W-1:0];

endmodule
